// File: rtl/lsu_pkg.sv
// Shared types, constants and request-checking helpers for the load/store unit.
//   lsu_state_e  : control FSM state encoding
//   F3_*         : RV32I load/store width codes (funct3)
//   lsu_fault()  : decides whether a request is rejected before touching memory
//   force_align(): clears the low address bits of a halfword/word access
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RMW_READ,
        ACCESS,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Illegal width and out-of-range always fault; misalignment only when checking is on.
    function automatic logic lsu_fault(input logic        write,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit,
                                       input logic        misalign_check);
        return !funct3_legal(write, funct3) || (addr >= limit) ||
               (misalign_check && is_misaligned(funct3, addr[1:0]));
    endfunction

    function automatic logic [31:0] force_align(input logic [2:0] funct3,
                                                input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        case (funct3)
            F3_H, F3_HU: a[0]   = 1'b0;
            F3_W:        a[1:0] = 2'b00;
            default: ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   funct3      : access width code of the latched request
//   byte_off    : address bits [1:0] of the latched request
//   store_data  : low halfword of the store data (sub-word stores only)
//   mem_word    : word currently read from memory
//   merged_word : mem_word with the addressed byte/halfword replaced by store_data
//   load_data   : addressed lane of mem_word, sign- or zero-extended per funct3
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [15:0] store_data,
    input  logic [31:0] mem_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = mem_word[7:0];
            2'd1:    sel_byte = mem_word[15:8];
            2'd2:    sel_byte = mem_word[23:16];
            default: sel_byte = mem_word[31:24];
        endcase
        sel_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        if (funct3 == F3_B) begin
            case (byte_off)
                2'd0:    merged_word[7:0]   = store_data[7:0];
                2'd1:    merged_word[15:8]  = store_data[7:0];
                2'd2:    merged_word[23:16] = store_data[7:0];
                default: merged_word[31:24] = store_data[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (byte_off[1]) begin
                merged_word[31:16] = store_data;
            end else begin
                merged_word[15:0] = store_data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit bridging a valid/ready request/response pair onto a
// word-wide data memory (combinational read, synchronous write).
// Sub-word stores are done as read-modify-write.
//   Request : req_valid/req_ready, req_write, req_funct3, req_addr, req_wdata
//   Response: resp_valid/resp_ready, resp_rdata, resp_fault
//   Memory  : mem_byte_address, mem_write_data, mem_MemWrite, mem_MemRead, mem_read_data
// Parameter MEM_BYTES: addressable bytes; addresses at or above it fault.
// Macro LSU_MISALIGN_CHECK_EN: when defined, misaligned halfword/word accesses
// fault; otherwise they are force-aligned and complete normally.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_byte_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic MISALIGN_CHECK = 1'b1;
`else
    localparam logic MISALIGN_CHECK = 1'b0;
`endif

    lsu_state_e  state;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        req_fault;
    logic [31:0] eff_addr;
    logic [31:0] merged_word;
    logic [31:0] load_data;

    assign req_fault = lsu_fault(req_write, req_funct3, req_addr, 32'(MEM_BYTES),
                                 MISALIGN_CHECK);
    // Without misalignment checking the access simply lands on the aligned lane.
    assign eff_addr  = MISALIGN_CHECK ? req_addr : force_align(req_funct3, req_addr);

    lsu_align u_align (
        .funct3      (f3_q),
        .byte_off    (off_q),
        .store_data  (wdata_q),
        .mem_word    (mem_read_data),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Outputs are registered and set on the transition into each state, so
    // memory strobes are active exactly while the FSM sits in RMW_READ/ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wr_q             <= 1'b0;
            f3_q             <= 3'b000;
            off_q            <= 2'b00;
            wdata_q          <= 16'h0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'h0;
            resp_fault       <= 1'b0;
            mem_byte_address <= 32'h0;
            mem_write_data   <= 32'h0;
            mem_MemWrite     <= 1'b0;
            mem_MemRead      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        f3_q      <= req_funct3;
                        off_q     <= eff_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            mem_byte_address <= {eff_addr[31:2], 2'b00};
                            if (req_write && (req_funct3 != F3_W)) begin
                                mem_MemRead <= 1'b1;
                                state       <= RMW_READ;
                            end else if (req_write) begin
                                mem_MemWrite   <= 1'b1;
                                mem_write_data <= req_wdata;
                                state          <= ACCESS;
                            end else begin
                                mem_MemRead <= 1'b1;
                                state       <= ACCESS;
                            end
                        end
                    end
                end
                RMW_READ: begin
                    mem_MemRead    <= 1'b0;
                    mem_MemWrite   <= 1'b1;
                    mem_write_data <= merged_word;
                    state          <= ACCESS;
                end
                ACCESS: begin
                    mem_MemRead      <= 1'b0;
                    mem_MemWrite     <= 1'b0;
                    mem_byte_address <= 32'h0;
                    mem_write_data   <= 32'h0;
                    resp_valid       <= 1'b1;
                    resp_fault       <= 1'b0;
                    resp_rdata       <= wr_q ? 32'h0 : load_data;
                    state            <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= 32'h0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_byte_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_byte_address (mem_byte_address),
        .mem_write_data   (mem_write_data),
        .mem_MemWrite     (mem_MemWrite),
        .mem_MemRead      (mem_MemRead),
        .mem_read_data    (mem_read_data)
    );

    // Memory model: 256 words, combinational read, synchronous write.
    logic [31:0] mem [0:255];
    assign mem_read_data = (mem_byte_address < 32'd1024) ? mem[mem_byte_address[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_MemWrite && (mem_byte_address < 32'd1024)) begin
            mem[mem_byte_address[9:2]] <= mem_write_data;
        end
    end

    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_MemWrite) wr_cnt <= wr_cnt + 1;
        if (mem_MemRead)  rd_cnt <= rd_cnt + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] exp_addr = 32'h0;

    // Monitor: checks memory address while strobes are active and pops the
    // scoreboard on each completed response.
    logic        in_resp = 1'b0;
    int          first_cyc = 0;
    logic [31:0] held_rdata = 32'h0;
    logic        held_fault = 1'b0;
    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            in_resp = 1'b0;
        end else begin
            if (mem_MemRead || mem_MemWrite) check("mem_addr", mem_byte_address, exp_addr);
            else check("mem_addr_idle", mem_byte_address, 32'h0);
            if (resp_valid) begin
                check("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                if (!in_resp) begin
                    in_resp    = 1'b1;
                    first_cyc  = cyc;
                    held_rdata = resp_rdata;
                    held_fault = resp_fault;
                end else begin
                    check("rdata_held", resp_rdata, held_rdata);
                    check("fault_held", {31'h0, resp_fault}, {31'h0, held_fault});
                end
                if (resp_ready) begin
                    in_resp = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got response with none expected");
                    end else begin
                        it = exp_q.pop_front();
                        check("resp_rdata", resp_rdata, it.rdata);
                        check("resp_fault", {31'h0, resp_fault}, {31'h0, it.fault});
                        check("resp_latency", 32'(first_cyc - it.acc + 1), 32'(it.lat));
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef,
                         input int el, input int hold);
        exp_t it;
        int   wr0, rd0, t;
        int   exp_wr, exp_rd;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        exp_wr = (!ef && w) ? 1 : 0;
        exp_rd = (!ef && (!w || f3 != F3_W)) ? 1 : 0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        exp_addr   = {a[31:2], 2'b00};
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        it.rdata = er;
        it.fault = ef;
        it.lat   = el;
        it.acc   = cyc;
        exp_q.push_back(it);
        req_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check("resp_valid_hold", {31'h0, resp_valid}, 32'h1);
            end
            resp_ready = 1'b1;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got no response expected one");
            exp_q.delete();
        end
        @(negedge clk);
        check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("read_count", 32'(rd_cnt - rd0), 32'(exp_rd));
    endtask

    initial begin
        int wr0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8]   = 32'h1122_3344;
        mem[255] = 32'hA5A5_5A5A;

        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_read", {31'h0, mem_MemRead}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'h0, req_ready}, 32'h1);
        check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset_resp_fault", {31'h0, resp_fault}, 32'h0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        check("reset_mem_write", {31'h0, mem_MemWrite}, 32'h0);

        // write, read back, sub-word stores
        issue(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0);
        check("sw_word4", mem[4], 32'hDEAD_BEEF);
        issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
        issue(1'b1, F3_B, 32'h13, 32'h0000_0012, 32'h0, 1'b0, 3, 0);
        check("sb_word4", mem[4], 32'h12AD_BEEF);
        issue(1'b1, F3_B, 32'h11, 32'hFFFF_FF80, 32'h0, 1'b0, 3, 0);
        check("sb2_word4", mem[4], 32'h12AD_80EF);

        // lane extraction and extension
        issue(1'b0, F3_B,  32'h11, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
        issue(1'b0, F3_BU, 32'h11, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
        issue(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_12AD, 1'b0, 2, 0);
        issue(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFF_80EF, 1'b0, 2, 0);
        issue(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 2, 0);
        issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0012, 1'b0, 2, 0);

        issue(1'b1, F3_H, 32'h22, 32'hCAFE_1234, 32'h0, 1'b0, 3, 0);
        check("sh_word8", mem[8], 32'h1234_3344);
        issue(1'b0, F3_W, 32'h3FC, 32'h0, 32'hA5A5_5A5A, 1'b0, 2, 0);

        // misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, F3_W, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b0, F3_H, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        issue(1'b0, F3_W, 32'h12, 32'h0, 32'h12AD_80EF, 1'b0, 2, 0);
        issue(1'b0, F3_H, 32'h13, 32'h0, 32'h0000_12AD, 1'b0, 2, 0);
`endif

        // out of range and illegal widths, one with a stalled consumer
        issue(1'b0, F3_W, 32'h400, 32'h0, 32'h0, 1'b1, 1, 5);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
        issue(1'b1, F3_BU, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
        check("illegal_store_word4", mem[4], 32'h12AD_80EF);

        // reset during the read phase of a halfword store
        @(negedge clk);
        wr0        = wr_cnt;
        exp_addr   = 32'h20;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_read_active", {31'h0, mem_MemRead}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_read", {31'h0, mem_MemRead}, 32'h0);
        check("async_rst_write", {31'h0, mem_MemWrite}, 32'h0);
        check("async_rst_addr", mem_byte_address, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rmw_abort_writes", 32'(wr_cnt - wr0), 32'h0);
        check("rmw_abort_word8", mem[8], 32'h1234_3344);
        issue(1'b0, F3_W, 32'h20, 32'h0, 32'h1234_3344, 1'b0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
